// File: rtl/osc_axil_pkg.sv
// osc_axil_pkg: register map constants and byte-strobe merge shared by the oscillator AXI-Lite slave.
package osc_axil_pkg;
  localparam logic [1:0] OSC_REG_CTRL      = 2'd0;
  localparam logic [1:0] OSC_REG_PHASE_INC = 2'd1;
  localparam logic [1:0] OSC_REG_WAVE      = 2'd2;
  localparam logic [1:0] OSC_REG_AMP       = 2'd3;
  localparam logic [1:0] RESP_OKAY         = 2'b00;
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/osc_axil_wr_capture.sv
// osc_axil_wr_capture: joins independent AW and W handshakes into one commit and owns the B channel.
module osc_axil_wr_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  aw_idx_i,
  input  logic        aw_valid_i,
  output logic        aw_ready_o,
  input  logic [31:0] w_data_i,
  input  logic [3:0]  w_strb_i,
  input  logic        w_valid_i,
  output logic        w_ready_o,
  input  logic        b_ready_i,
  output logic        b_valid_o,
  output logic        commit_o,
  output logic [1:0]  idx_o,
  output logic [31:0] data_o,
  output logic [3:0]  strb_o
);
  logic        aw_held_q, w_held_q, b_valid_q;
  logic [1:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs;
  assign aw_ready_o = !aw_held_q && !b_valid_q;
  assign w_ready_o  = !w_held_q && !b_valid_q;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign w_hs       = w_valid_i && w_ready_o;
  // A half may arrive now or may have been parked earlier; commit once both exist.
  assign commit_o   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign idx_o      = aw_held_q ? aw_idx_q : aw_idx_i;
  assign data_o     = w_held_q ? w_data_q : w_data_i;
  assign strb_o     = w_held_q ? w_strb_q : w_strb_i;
  assign b_valid_o  = b_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      b_valid_q <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit_o) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      b_valid_q <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= aw_idx_i;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end
      if (b_valid_q && b_ready_i) b_valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/oscillator_axil_regs.sv
// oscillator_axil_regs: AXI4-Lite slave holding the oscillator's four control registers.
module oscillator_axil_regs
  import osc_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   osc_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   osc_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   osc_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   osc_reg3,
  output logic [3:0]                      osc_reg_wr
);
  logic [31:0] regs_q [4];
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic [3:0]  wr_q;
  logic        commit;
  logic [1:0]  commit_idx;
  logic [31:0] commit_data;
  logic [3:0]  commit_strb;
  logic        unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  osc_axil_wr_capture u_wr (
    .clk        (S_AXI_ACLK),
    .rst        (S_AXI_ARESET),
    .aw_idx_i   (S_AXI_AWADDR[3:2]),
    .aw_valid_i (S_AXI_AWVALID),
    .aw_ready_o (S_AXI_AWREADY),
    .w_data_i   (S_AXI_WDATA),
    .w_strb_i   (S_AXI_WSTRB),
    .w_valid_i  (S_AXI_WVALID),
    .w_ready_o  (S_AXI_WREADY),
    .b_ready_i  (S_AXI_BREADY),
    .b_valid_o  (S_AXI_BVALID),
    .commit_o   (commit),
    .idx_o      (commit_idx),
    .data_o     (commit_data),
    .strb_o     (commit_strb)
  );
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign osc_reg0      = regs_q[OSC_REG_CTRL];
  assign osc_reg1      = regs_q[OSC_REG_PHASE_INC];
  assign osc_reg2      = regs_q[OSC_REG_WAVE];
  assign osc_reg3      = regs_q[OSC_REG_AMP];
  assign osc_reg_wr    = wr_q;
  // Read samples the register array before this edge's write lands, so a same-edge read sees the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      wr_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_q <= commit ? 4'b0001 << commit_idx : 4'b0000;
      if (commit) regs_q[commit_idx] <= apply_wstrb(regs_q[commit_idx], commit_data, commit_strb);
      if (S_AXI_ARVALID && !rvalid_q) begin
        rdata_q  <= regs_q[S_AXI_ARADDR[3:2]];
        rvalid_q <= 1'b1;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_oscillator_axil_regs.sv
// tb_oscillator_axil_regs: directed checks of the oscillator AXI-Lite register slave.
module tb_oscillator_axil_regs;
  logic        clk = 0, rst = 1;
  logic [3:0]  awaddr = 0, araddr = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, r0, r1, r2, r3;
  logic [3:0]  wr;
  int n_tests = 0, n_fail = 0;

  oscillator_axil_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .osc_reg0(r0), .osc_reg1(r1), .osc_reg2(r2), .osc_reg3(r3), .osc_reg_wr(wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    check("wr_awready", {31'd0, awready}, 1);
    check("wr_wready", {31'd0, wready}, 1);
    @(negedge clk);
    check("wr_bvalid", {31'd0, bvalid}, 1);
    check("wr_bresp", {30'd0, bresp}, 0);
    check("wr_pulse", {28'd0, wr}, {28'd0, 4'b0001 << a[3:2]});
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("wr_bvalid_clr", {31'd0, bvalid}, 0);
    check("wr_pulse_clr", {28'd0, wr}, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    check("rd_arready", {31'd0, arready}, 1);
    @(negedge clk);
    check("rd_rvalid", {31'd0, rvalid}, 1);
    check("rd_rdata", rdata, exp);
    check("rd_rresp", {30'd0, rresp}, 0);
    arvalid = 0;
    @(negedge clk);
    check("rd_rvalid_clr", {31'd0, rvalid}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_bvalid", {31'd0, bvalid}, 0);
    check("rst_rvalid", {31'd0, rvalid}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wr", {28'd0, wr}, 0);
    check("rst_reg0", r0, 0);
    check("rst_reg3", r3, 0);
    // Basic writes and read-back
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'(i + 1));
    // Byte strobes
    axi_write(4'h4, 32'hAABBCCDD, 4'hF);
    axi_write(4'h4, 32'h11223344, 4'b0101);
    check("strb_reg1", r1, 32'hAA22CC44);
    axi_read(4'h4, 32'hAA22CC44);
    axi_write(4'h4, 32'hFFFFFFFF, 4'b0000);
    check("strb0_reg1", r1, 32'hAA22CC44);
    // W leads AW by three cycles
    @(negedge clk);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1; bready = 1;
    check("wfirst_wready", {31'd0, wready}, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wfirst_wready_low", {31'd0, wready}, 0);
      check("wfirst_no_b", {31'd0, bvalid}, 0);
    end
    awaddr = 4'hC; awvalid = 1;
    check("wfirst_awready", {31'd0, awready}, 1);
    @(negedge clk);
    check("wfirst_bvalid", {31'd0, bvalid}, 1);
    check("wfirst_wr", {28'd0, wr}, 4'b1000);
    check("wfirst_reg3", r3, 32'hCAFEF00D);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("wfirst_bclr", {31'd0, bvalid}, 0);
    // BREADY stalled: second write must wait for the B handshake
    awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    check("stall_bvalid0", {31'd0, bvalid}, 1);
    check("stall_reg0", r0, 32'h77);
    awaddr = 4'h4; wdata = 32'h88;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_bvalid", {31'd0, bvalid}, 1);
      check("stall_awready", {31'd0, awready}, 0);
      check("stall_wready", {31'd0, wready}, 0);
    end
    check("stall_reg1_kept", r1, 32'hAA22CC44);
    bready = 1;
    @(negedge clk);
    check("stall_b_done", {31'd0, bvalid}, 0);
    check("stall_reg1_still", r1, 32'hAA22CC44);
    @(negedge clk);
    check("stall_2nd_bvalid", {31'd0, bvalid}, 1);
    check("stall_2nd_wr", {28'd0, wr}, 4'b0010);
    check("stall_2nd_reg1", r1, 32'h88);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    // Same-edge read and write to one register
    axi_write(4'h8, 32'h5, 4'hF);
    @(negedge clk);
    araddr = 4'h8; arvalid = 1; rready = 1;
    awaddr = 4'h8; wdata = 32'h9; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    check("same_rvalid", {31'd0, rvalid}, 1);
    check("same_rdata", rdata, 32'h5);
    check("same_bvalid", {31'd0, bvalid}, 1);
    check("same_reg2", r2, 32'h9);
    arvalid = 0; awvalid = 0; wvalid = 0;
    @(negedge clk);
    axi_read(4'h8, 32'h9);
    // Reset with a held AW and a pending read response
    @(negedge clk);
    awaddr = 4'h4; awvalid = 1; araddr = 4'h0; arvalid = 1; rready = 0;
    @(negedge clk);
    check("pre_rst_awready", {31'd0, awready}, 0);
    check("pre_rst_rvalid", {31'd0, rvalid}, 1);
    awvalid = 0; arvalid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_rvalid", {31'd0, rvalid}, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_bvalid", {31'd0, bvalid}, 0);
    check("mid_rst_wr", {28'd0, wr}, 0);
    check("mid_rst_awready", {31'd0, awready}, 1);
    check("mid_rst_regs", r0 | r1 | r2 | r3, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'h0);
    @(negedge clk);
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1; bready = 1;
    @(negedge clk);
    check("post_rst_no_b", {31'd0, bvalid}, 0);
    check("post_rst_reg1", r1, 0);
    wvalid = 0;
    @(negedge clk);
    check("post_rst_no_b2", {31'd0, bvalid}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
